mc_ctrl_fsm: RTL

Multicycle control unit for the MIPS-subset datapath: a Moore FSM that sequences a shared ALU/memory datapath over 3-5 cycles per instruction. It supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j. It drives all datapath enables and muxes, stalls on a memory-ready handshake, flags illegal instructions, and counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_ctrl_fsm_if.sv | 40 ++++
 rtl/mc_ctrl_fsm_alu_decoder.sv | 37 +++
 rtl/mc_ctrl_fsm.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS-subset control unit:
//   - state_t      : 4-bit FSM state encoding (codes 12-15 unused)
//   - OP_* / FN_*  : opcode and R-type function field constants
//   - alu_op_t     : 2-bit ALU operation class handed to the ALU decoder
//   - ALUC_*       : 3-bit alu_control codes driven to the datapath ALU
//   - funct_is_legal : R-type function field legality check
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    // True when the R-type function field names a supported ALU operation.
    function automatic logic funct_is_legal(input logic [5:0] f);
        logic ok;
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Control/status bundle between the multicycle control unit and the datapath.
//   Datapath -> control : op, funct, zero, mem_ready
//   Control -> datapath : iord, mem_write, ir_write, reg_dst, mem_to_reg,
//                         reg_write, alu_src_a, alu_src_b, alu_control,
//                         pc_src, pc_en, illegal_op
// master = control unit, slave = datapath.
// ---------------------------------------------------------------------------
interface mc_ctrl_fsm_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;

    modport master (
        input  op, funct, zero, mem_ready,
        output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal_op
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal_op
    );
endinterface

// File: rtl/mc_ctrl_fsm_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode.
//   alu_op_i      : operation class (add / sub / use funct)
//   funct_i       : R-type function field
//   alu_control_o : 3-bit ALU operation select
// ---------------------------------------------------------------------------
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_t    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    // Map operation class and function field onto the ALU control code.
    always_comb begin
        alu_control_o = ALUC_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALUC_ADD;
            ALUOP_SUB: alu_control_o = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_control_o = ALUC_ADD;
                    FN_SUB:  alu_control_o = ALUC_SUB;
                    FN_AND:  alu_control_o = ALUC_AND;
                    FN_OR:   alu_control_o = ALUC_OR;
                    FN_SLT:  alu_control_o = ALUC_SLT;
                    // Illegal functs never reach EXECUTE; add is a safe filler.
                    default: alu_control_o = ALUC_ADD;
                endcase
            end
            default: alu_control_o = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Moore control FSM for a multicycle MIPS-subset datapath (R-type add/sub/
// and/or/slt, lw, sw, beq, addi, j). Sequences one instruction over 3-5
// cycles, stretching FETCH/MEMRD/MEMWR while mem_ready is low.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : mc_ctrl_fsm_if.master (opcode/flags in, datapath controls out)
//   instret  : retired-instruction counter, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mc_ctrl_fsm_if.master        bus,
    output logic [CNT_W-1:0]     instret
);

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    alu_op_t          alu_op_s;
    logic [2:0]       alu_ctl_s;
    logic             pc_write_s;
    logic             branch_s;
    logic             retire_s;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op_s),
        .funct_i       (bus.funct),
        .alu_control_o (alu_ctl_s)
    );

    // State, illegal-op pulse and retire counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // Next-state selection, illegal-op detection and retire accounting.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = 1'b0;
        retire_s  = 1'b0;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_is_legal(bus.funct)) begin
                            state_d = S_EXECUTE;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d  = S_MEMWR;
                end
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_ADDIEX:  state_d = S_ADDIWB;
            // Unused codes 12-15 recover to FETCH without retiring.
            default:   state_d = S_FETCH;
        endcase

        if (retire_s) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_q;
        end
    end

    // Moore output decode; everything is held at zero while reset is low so
    // that no strobe (including FETCH's mem_ready-gated ones) can leak out.
    always_comb begin
        bus.iord        = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.alu_control = 3'b000;
        bus.pc_src      = 2'b00;
        bus.pc_en       = 1'b0;
        alu_op_s        = ALUOP_ADD;
        pc_write_s      = 1'b0;
        branch_s        = 1'b0;
        if (!reset_n) begin
            alu_op_s = ALUOP_ADD;
        end else begin
            case (state_q)
                S_FETCH: begin
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    pc_write_s    = bus.mem_ready;
                end
                S_DECODE:  bus.alu_src_b = 2'b11;
                S_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEMRD:   bus.iord = 1'b1;
                S_MEMWB: begin
                    bus.mem_to_reg = 1'b1;
                    bus.reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    bus.iord      = 1'b1;
                    bus.mem_write = 1'b1;
                end
                S_EXECUTE: begin
                    bus.alu_src_a = 1'b1;
                    alu_op_s      = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    bus.reg_dst   = 1'b1;
                    bus.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    bus.pc_src    = 2'b01;
                    alu_op_s      = ALUOP_SUB;
                    branch_s      = 1'b1;
                end
                S_ADDIEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_ADDIWB:  bus.reg_write = 1'b1;
                S_JUMP: begin
                    bus.pc_src = 2'b10;
                    pc_write_s = 1'b1;
                end
                default:   alu_op_s = ALUOP_ADD;
            endcase
            bus.alu_control = alu_ctl_s;
            bus.pc_en       = pc_write_s | (branch_s & bus.zero);
        end
    end

    assign bus.illegal_op = illegal_q;
    assign instret        = instret_q;

endmodule
